sync_frame_tx: RTL

SYNC_FRAME_TX -- requirements
Module: sync_frame_tx

---
 rtl/sync_frame_pkg.sv | 24 ++
 rtl/flex_pts_sr.sv | 36 +++
 rtl/sync_frame_tx.sv | 112 +++++++++++
 3 files changed

// File: rtl/sync_frame_pkg.sv
// Shared definitions for the synchronous framed serial transmitter.
// Holds the FSM state type, the sync pattern and a helper that sizes the
// bit counter so it can index both the sync pattern and the payload.
package sync_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Transmitted MSB first: 1,1,0,1
  localparam logic [3:0] SYNC_PATTERN = 4'b1101;
  localparam int         SYNC_LEN     = 4;

  // Counter must reach SYNC_LEN-1 and DATA_BITS-1, never narrower than 2 bits
  function automatic int cnt_width(input int data_bits);
    int w;
    w = $clog2(data_bits);
    return (w < 2) ? 2 : w;
  endfunction

endpackage

// File: rtl/flex_pts_sr.sv
// Parallel-load, MSB-first parallel-to-serial shift register.
// Ports:
//   clk          rising-edge clock
//   n_rst        asynchronous active-low reset, clears the register
//   load_enable  load parallel_in (has priority over shift)
//   shift_enable shift left by one, zero fill
//   parallel_in  NUM_BITS-wide word to load
//   serial_out   current MSB of the register (combinational from the flops)
module flex_pts_sr
  import sync_frame_pkg::*;
#(
  parameter int NUM_BITS = 8
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                load_enable,
  input  logic                shift_enable,
  input  logic [NUM_BITS-1:0] parallel_in,
  output logic                serial_out
);

  logic [NUM_BITS-1:0] sr_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sr_q <= '0;
    end else if (load_enable) begin
      sr_q <= parallel_in;
    end else if (shift_enable) begin
      sr_q <= {sr_q[NUM_BITS-2:0], 1'b0};
    end
  end

  assign serial_out = sr_q[NUM_BITS-1];

endmodule

// File: rtl/sync_frame_tx.sv
// Synchronous frame transmitter: sends the 4-bit sync pattern 1101 followed
// by a DATA_BITS payload, MSB first, one bit per clock, then pulses done.
// Ports:
//   clk         rising-edge clock
//   n_rst       asynchronous active-low reset (aborts any frame in flight)
//   start       frame request, accepted in IDLE or DONE only
//   data_in     payload, captured on the edge that accepts start
//   serial_out  registered serial stream, IDLE_LEVEL between frames
//   busy        registered, high while sync or payload bits are on serial_out
//   done        registered one-cycle completion pulse
module sync_frame_tx
  import sync_frame_pkg::*;
#(
  parameter int   DATA_BITS  = 8,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 serial_out,
  output logic                 busy,
  output logic                 done
);

  localparam int               CNT_W     = cnt_width(DATA_BITS);
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;       // index of the bit currently on serial_out
  logic             accept;
  logic             shift_en;
  logic             payload_msb;
  logic [1:0]       sync_idx;

  assign accept = start && ((state == ST_IDLE) || (state == ST_DONE));

  // The register's MSB is always the next payload bit to drive; consume it
  // whenever it is being moved onto serial_out.
  assign shift_en = ((state == ST_SYNC) && (cnt == SYNC_LAST)) ||
                    ((state == ST_DATA) && (cnt != DATA_LAST));

  // Pattern bit for the following sync cycle (cnt+1), pattern sent MSB first
  assign sync_idx = 2'd2 - cnt[1:0];

  flex_pts_sr #(
    .NUM_BITS(DATA_BITS)
  ) u_sr (
    .clk         (clk),
    .n_rst       (n_rst),
    .load_enable (accept),
    .shift_enable(shift_en),
    .parallel_in (data_in),
    .serial_out  (payload_msb)
  );

  // Outputs are registered with the values of the state being entered
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      serial_out <= IDLE_LEVEL;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            state      <= ST_SYNC;
            cnt        <= '0;
            serial_out <= SYNC_PATTERN[3];
            busy       <= 1'b1;
          end else begin
            state      <= ST_IDLE;
            serial_out <= IDLE_LEVEL;
            busy       <= 1'b0;
          end
        end
        ST_SYNC: begin
          if (cnt == SYNC_LAST) begin
            state      <= ST_DATA;
            cnt        <= '0;
            serial_out <= payload_msb;
          end else begin
            cnt        <= cnt + CNT_W'(1);
            serial_out <= SYNC_PATTERN[sync_idx];
          end
        end
        ST_DATA: begin
          if (cnt == DATA_LAST) begin
            state      <= ST_DONE;
            serial_out <= IDLE_LEVEL;
            busy       <= 1'b0;
            done       <= 1'b1;
          end else begin
            cnt        <= cnt + CNT_W'(1);
            serial_out <= payload_msb;
          end
        end
        default: begin
          state      <= ST_IDLE;
          serial_out <= IDLE_LEVEL;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule
